// File: rtl/wishbone_master_adapter.sv
// Single-outstanding Wishbone classic master: turns one core request into one
// STB/CYC cycle, reporting either the ACKed result or a timeout error.
module wishbone_master_adapter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic [3:0]  cpu_sel_i,
  output logic        cpu_ready_o,
  output logic        cpu_rvalid_o,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_err_o,
  output logic [31:0] wb_addr_o,
  output logic [31:0] wb_data_o,
  input  logic [31:0] wb_data_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Last wait cycle; leaving BUS here keeps the 8-bit counter from ever wrapping.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_we;
  logic [3:0]  r_sel;
  logic        r_err;
  logic [7:0]  r_cnt;
  logic        w_accept;
  logic        w_ack;
  logic        w_timeout;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_ack        = 1'b0;
    w_timeout    = 1'b0;
    cpu_ready_o  = 1'b0;
    cpu_rvalid_o = 1'b0;
    wb_stb_o     = 1'b0;
    wb_cyc_o     = 1'b0;
    case (r_state)
      IDLE: begin
        cpu_ready_o = 1'b1;
        if (cpu_req_i) begin
          w_accept    = 1'b1;
          w_state_nxt = BUS;
        end
      end
      BUS: begin
        wb_stb_o = 1'b1;
        wb_cyc_o = 1'b1;
        // ACK has priority over a timeout landing on the same cycle.
        if (wb_ack_i) begin
          w_ack       = 1'b1;
          w_state_nxt = RESP;
        end else if (r_cnt == TO_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        cpu_rvalid_o = 1'b1;
        w_state_nxt  = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_we    <= 1'b0;
      r_sel   <= 4'h0;
      r_cnt   <= 8'h0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr  <= cpu_addr_i;
        r_wdata <= cpu_wdata_i;
        r_we    <= cpu_we_i;
        r_sel   <= cpu_sel_i;
        r_cnt   <= 8'h0;
      end else if ((r_state == BUS) && !w_ack && !w_timeout) begin
        r_cnt <= r_cnt + 8'h1;
      end
      // Write ACKs leave the previous read data visible.
      if (w_ack) begin
        r_err <= 1'b0;
        if (!r_we) begin
          r_rdata <= wb_data_i;
        end
      end else if (w_timeout) begin
        r_err   <= 1'b1;
        r_rdata <= 32'h0;
      end
    end
  end

  assign wb_addr_o   = r_addr;
  assign wb_data_o   = r_wdata;
  assign wb_we_o     = r_we;
  assign wb_sel_o    = r_sel;
  assign cpu_rdata_o = r_rdata;
  assign cpu_err_o   = r_err;

endmodule

// File: tb/tb_wishbone_master_adapter.sv
// Randomised and directed bench for wishbone_master_adapter with a
// cycle-numbered transaction model and a programmable Wishbone slave.
module tb_wishbone_master_adapter;

  localparam int T = 16;

  logic        clk;
  logic        rst;
  logic        cpu_req_i;
  logic        cpu_we_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_wdata_i;
  logic [3:0]  cpu_sel_i;
  logic        cpu_ready_o;
  logic        cpu_rvalid_o;
  logic [31:0] cpu_rdata_o;
  logic        cpu_err_o;
  logic [31:0] wb_addr_o;
  logic [31:0] wb_data_o;
  logic [31:0] wb_data_i;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i;

  int checks = 0;
  int failures = 0;

  int          slave_delay = 1;
  int          data_mode = 0;
  logic [31:0] fixed_data = 32'h0;
  bit          inject_ack = 1'b0;
  int          stb_run = 0;

  int          tot_stb = 0;
  int          tot_rv = 0;
  int          rise_q[$];
  logic [31:0] rv_data_q[$];

  int          cyc_n = 0;
  bit          m_open = 1'b0;
  int          m_acc = 0;
  int          m_resp = -1;
  logic [31:0] m_addr = 32'h0;
  logic [31:0] m_wdata = 32'h0;
  logic [31:0] m_rdata = 32'h0;
  logic        m_we = 1'b0;
  logic [3:0]  m_sel = 4'h0;
  logic        m_err = 1'b0;
  bit          prev_stb = 1'b0;

  wishbone_master_adapter #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_sel_i   (cpu_sel_i),
    .cpu_ready_o (cpu_ready_o),
    .cpu_rvalid_o(cpu_rvalid_o),
    .cpu_rdata_o (cpu_rdata_o),
    .cpu_err_o   (cpu_err_o),
    .wb_addr_o   (wb_addr_o),
    .wb_data_o   (wb_data_o),
    .wb_data_i   (wb_data_i),
    .wb_we_o     (wb_we_o),
    .wb_sel_o    (wb_sel_o),
    .wb_stb_o    (wb_stb_o),
    .wb_cyc_o    (wb_cyc_o),
    .wb_ack_i    (wb_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%08h required=%08h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Slave: ACK after slave_delay STB cycles have already elapsed.
  initial begin
    wb_ack_i  = 1'b0;
    wb_data_i = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (wb_stb_o) stb_run++;
      else stb_run = 0;
      wb_ack_i = inject_ack || (wb_stb_o && (stb_run == slave_delay + 1));
      case (data_mode)
        1:       wb_data_i = fixed_data;
        2:       wb_data_i = wb_addr_o ^ 32'hA5A5_0000;
        default: wb_data_i = $urandom();
      endcase
    end
  end

  // Model: transaction accepted in cycle acc has STB in cycles acc+1 .. until
  // the ACK cycle or cycle acc+T, and its response pulse one cycle later.
  initial begin
    forever begin
      @(negedge clk);
      if (wb_stb_o) tot_stb++;
      if (wb_stb_o && !prev_stb) rise_q.push_back(cyc_n);
      prev_stb = wb_stb_o;
      if (cpu_rvalid_o) begin
        tot_rv++;
        rv_data_q.push_back(cpu_rdata_o);
      end
      if (rst) begin
        chk1("rst_stb", wb_stb_o, 1'b0);
        chk1("rst_cyc", wb_cyc_o, 1'b0);
        chk1("rst_rvalid", cpu_rvalid_o, 1'b0);
        chk1("rst_err", cpu_err_o, 1'b0);
        chk1("rst_we", wb_we_o, 1'b0);
        chk("rst_addr", wb_addr_o, 32'h0);
        chk("rst_wdata", wb_data_o, 32'h0);
        chk("rst_rdata", cpu_rdata_o, 32'h0);
        chk({"rst_sel"}, {28'b0, wb_sel_o}, 32'h0);
        m_open  = 1'b0;
        m_resp  = -1;
        m_addr  = 32'h0;
        m_wdata = 32'h0;
        m_rdata = 32'h0;
        m_we    = 1'b0;
        m_sel   = 4'h0;
        m_err   = 1'b0;
      end else begin
        chk1("ready", cpu_ready_o, !m_open);
        chk1("stb", wb_stb_o, m_open && (m_resp < 0));
        chk1("cyc", wb_cyc_o, m_open && (m_resp < 0));
        chk1("rvalid", cpu_rvalid_o, m_open && (cyc_n == m_resp));
        if (m_open && (cyc_n == m_resp)) chk1("err", cpu_err_o, m_err);
        chk("rdata", cpu_rdata_o, m_rdata);
        chk("wb_addr", wb_addr_o, m_addr);
        chk("wb_data", wb_data_o, m_wdata);
        chk1("wb_we", wb_we_o, m_we);
        chk("wb_sel", {28'b0, wb_sel_o}, {28'b0, m_sel});
        if (!m_open) begin
          if (cpu_req_i) begin
            m_open  = 1'b1;
            m_acc   = cyc_n;
            m_resp  = -1;
            m_addr  = cpu_addr_i;
            m_wdata = cpu_wdata_i;
            m_we    = cpu_we_i;
            m_sel   = cpu_sel_i;
          end
        end else if (m_resp < 0) begin
          if (wb_ack_i) begin
            m_resp = cyc_n + 1;
            m_err  = 1'b0;
            if (!m_we) m_rdata = wb_data_i;
          end else if (cyc_n - m_acc == T) begin
            m_resp  = cyc_n + 1;
            m_err   = 1'b1;
            m_rdata = 32'h0;
          end
        end else if (cyc_n == m_resp) begin
          m_open = 1'b0;
        end
      end
      cyc_n++;
    end
  end

  task automatic cpu_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] sel, input int dly,
                         output logic [31:0] rd, output logic er, output int nstb);
    int s0;
    bit done;
    rd = 32'h0;
    er = 1'b0;
    @(negedge clk);
    slave_delay = dly;
    @(posedge clk);
    #1;
    s0 = tot_stb;
    cpu_req_i   = 1'b1;
    cpu_we_i    = we;
    cpu_addr_i  = addr;
    cpu_wdata_i = wdata;
    cpu_sel_i   = sel;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (cpu_ready_o) done = 1'b1;
    end
    chk1("txn_accepted", done, 1'b1);
    @(posedge clk);
    #1;
    cpu_req_i = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (cpu_rvalid_o) begin
        done = 1'b1;
        rd = cpu_rdata_o;
        er = cpu_err_o;
      end
    end
    chk1("txn_responded", done, 1'b1);
    nstb = tot_stb - s0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          n;
    int          rv0;
    int          rq0;
    int          vq0;
    int          dly;
    logic        we;
    bit          done;
    rst = 1'b1;
    cpu_req_i = 1'b0;
    cpu_we_i = 1'b0;
    cpu_addr_i = 32'h0;
    cpu_wdata_i = 32'h0;
    cpu_sel_i = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk1("ready_after_reset", cpu_ready_o, 1'b1);

    // Single read against the one-cycle-ACK slave.
    data_mode = 1;
    fixed_data = 32'hDEAD_BEEF;
    cpu_txn(1'b0, 32'h0000_0010, 32'h0, 4'hF, 1, rd, er, n);
    chk("read_data", rd, 32'hDEAD_BEEF);
    chk1("read_err", er, 1'b0);
    chk_int("read_stb_cycles", n, 2);

    // Single write: read data register must keep the previous value.
    cpu_txn(1'b1, 32'h20, 32'h1234_5678, 4'b0011, 1, rd, er, n);
    chk("write_rdata_kept", rd, 32'hDEAD_BEEF);
    chk1("write_err", er, 1'b0);
    chk_int("write_stb_cycles", n, 2);
    chk("write_addr", wb_addr_o, 32'h20);
    chk("write_data", wb_data_o, 32'h1234_5678);
    chk1("write_we", wb_we_o, 1'b1);
    chk("write_sel", {28'b0, wb_sel_o}, 32'h3);

    // Timeout followed by a stray late ACK.
    data_mode = 0;
    cpu_txn(1'b0, 32'h30, 32'h0, 4'hF, 255, rd, er, n);
    chk1("timeout_err", er, 1'b1);
    chk("timeout_rdata", rd, 32'h0);
    chk_int("timeout_stb_cycles", n, T);
    @(negedge clk);
    rv0 = tot_rv;
    inject_ack = 1'b1;
    repeat (2) @(negedge clk);
    inject_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk_int("late_ack_ignored", tot_rv, rv0);

    // ACK on the final timeout cycle.
    data_mode = 1;
    fixed_data = 32'hC0DE_0001;
    cpu_txn(1'b0, 32'h40, 32'h0, 4'hF, T - 1, rd, er, n);
    chk1("coincide_err", er, 1'b0);
    chk("coincide_rdata", rd, 32'hC0DE_0001);
    chk_int("coincide_stb_cycles", n, T);

    // Back-to-back reads with request held high.
    @(negedge clk);
    data_mode = 2;
    slave_delay = 1;
    rq0 = rise_q.size();
    vq0 = rv_data_q.size();
    @(posedge clk);
    #1;
    cpu_req_i = 1'b1;
    cpu_we_i = 1'b0;
    cpu_addr_i = 32'h100;
    n = 0;
    for (int i = 0; i < 60 && n < 3; i++) begin
      @(negedge clk);
      if (cpu_ready_o) begin
        n++;
        @(posedge clk);
        #1;
        if (n < 3) cpu_addr_i = 32'h100 + 32'(n * 16);
        else cpu_req_i = 1'b0;
      end
    end
    cpu_req_i = 1'b0;
    chk_int("b2b_accepts", n, 3);
    for (int i = 0; i < 60 && rv_data_q.size() < vq0 + 3; i++) @(negedge clk);
    @(negedge clk);
    chk_int("b2b_responses", rv_data_q.size() - vq0, 3);
    if (rv_data_q.size() >= vq0 + 3) begin
      for (int k = 0; k < 3; k++)
        chk("b2b_data", rv_data_q[vq0 + k], (32'h100 + 32'(k * 16)) ^ 32'hA5A5_0000);
    end
    if (rise_q.size() >= rq0 + 3) begin
      for (int k = 1; k < 3; k++)
        chk_int("b2b_spacing", rise_q[rq0 + k] - rise_q[rq0 + k - 1], 4);
    end

    // Random traffic including timeouts and ACK/timeout coincidence.
    data_mode = 0;
    for (int t = 0; t < 60; t++) begin
      we  = 1'($urandom_range(0, 1));
      dly = int'($urandom_range(0, 20));
      cpu_txn(we, $urandom(), $urandom(), 4'($urandom_range(0, 15)), dly, rd, er, n);
      chk1("rand_err", er, dly >= T);
      chk_int("rand_stb_cycles", n, (dly + 1 < T) ? dly + 1 : T);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Reset while the bus cycle is in flight.
    @(negedge clk);
    slave_delay = 255;
    @(posedge clk);
    #1;
    cpu_req_i = 1'b1;
    cpu_we_i = 1'b0;
    cpu_addr_i = 32'h200;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (cpu_ready_o) done = 1'b1;
    end
    @(posedge clk);
    #1;
    cpu_req_i = 1'b0;
    @(negedge clk);
    chk1("pre_reset_stb", wb_stb_o, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk1("async_reset_stb", wb_stb_o, 1'b0);
    chk1("async_reset_cyc", wb_cyc_o, 1'b0);
    rv0 = tot_rv;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk1("ready_after_abort", cpu_ready_o, 1'b1);
    repeat (20) @(negedge clk);
    chk_int("no_resp_after_abort", tot_rv, rv0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
